// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: level constants, state encoding and clog2 shared by the frame buffer clients
package frame_buf_pkg;
  localparam logic ASSERT = 1'b1;
  localparam logic DEASSERT = 1'b0;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fb_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; DEPTH must be a power of 2
module sync_fifo
  import frame_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        empty,
  output logic                        full
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end
  assign rdata = mem_q[rp_q];
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
endmodule

// File: rtl/frame_buf_reader.sv
// frame_buf_reader: fetches one frame from the frame buffer and streams it out with sof/eof
module frame_buf_reader
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fb_rd_en_l,
  input  logic [DATA_WIDTH-1:0] fb_rd_data,
  input  logic                  fb_rd_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int IW = clog2(FRAME_LEN + 1);
  localparam int CW = clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] LEN = IW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);
  fb_state_e state_q, state_d;
  logic [IW-1:0] issued_q, issued_d, accepted_q, accepted_d;
  logic [CW-1:0] outstanding_q, outstanding_d, fifo_count;
  logic done_q, done_d;
  logic req, push, pop, last, empty, full;
  logic [DATA_WIDTH-1:0] head;
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .wdata(fb_rd_data), .pop(pop),
    .rdata(head), .count(fifo_count), .empty(empty), .full(full)
  );
  // Requests are credited against in-flight responses plus queued words, so the FIFO cannot overflow.
  always_comb begin
    req = state_q == FETCH && issued_q < LEN && {1'b0, outstanding_q} + {1'b0, fifo_count} < CREDITS;
    push = fb_rd_valid && outstanding_q != '0;
    pop = !empty && m_ready;
    last = pop && accepted_q == LAST;
    issued_d = state_q == IDLE ? '0 : issued_q + IW'(req);
    accepted_d = state_q == IDLE ? '0 : accepted_q + IW'(pop);
    outstanding_d = state_q == IDLE ? '0 : outstanding_q + CW'(req) - CW'(push);
    done_d = last ? ASSERT : DEASSERT;
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? FETCH : IDLE)
            : last ? IDLE
            : state_q == FETCH && issued_d == LEN ? DRAIN : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      issued_q <= '0;
      accepted_q <= '0;
      outstanding_q <= '0;
      done_q <= DEASSERT;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      accepted_q <= accepted_d;
      outstanding_q <= outstanding_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    fb_rd_en_l = !req;
    m_valid = !empty;
    m_data = m_valid ? head : '0;
    m_sof = m_valid && accepted_q == '0;
    m_eof = m_valid && accepted_q == LAST;
    busy = state_q != IDLE;
    frame_done = done_q;
  end
  // A credited response must answer the request made RD_LAT cycles earlier.
  assert property (@(posedge clk) disable iff (reset) push |-> $past(req, RD_LAT));
  assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule
